// File: rtl/traffic_phase_controller_if.sv
// Signal bundle between the junction controller and its surroundings.
// The controller takes the slave view; the driving environment takes the master view.
interface traffic_phase_controller_if;
    logic       side_req;
    logic       flash_mode;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic [2:0] phase;
    logic       demand_pending;

    modport master (
        output side_req, flash_mode,
        input  light_M1, light_M2, light_MT, light_S, phase, demand_pending
    );

    modport slave (
        input  side_req, flash_mode,
        output light_M1, light_M2, light_MT, light_S, phase, demand_pending
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// Demand-actuated junction controller: main roads rest on green, side phase on demand only,
// flashing night mode entered from all-red. All timing is in prescaled ticks.
module traffic_phase_controller #(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned T_MAIN     = 7,
    parameter int unsigned T_MAIN_MAX = 20,
    parameter int unsigned T_YEL      = 2,
    parameter int unsigned T_TURN     = 5,
    parameter int unsigned T_SIDE     = 3,
    parameter int unsigned T_CLR      = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    traffic_phase_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        StMGreen  = 3'd0,
        StM2Yel   = 3'd1,
        StMtGreen = 3'd2,
        StM1MtYel = 3'd3,
        StSGreen  = 3'd4,
        StSYel    = 3'd5,
        StAllRed  = 3'd6,
        StFlash   = 3'd7
    } state_e;

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PreMax  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MainMin = CNT_W'(T_MAIN - 1);
    localparam logic [CNT_W-1:0] MainMax = CNT_W'(T_MAIN_MAX - 1);
    localparam logic [CNT_W-1:0] YelEnd  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] TurnEnd = CNT_W'(T_TURN - 1);
    localparam logic [CNT_W-1:0] SideEnd = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] ClrEnd  = CNT_W'(T_CLR - 1);

    localparam logic [2:0] LRed = 3'b100;
    localparam logic [2:0] LYel = 3'b010;
    localparam logic [2:0] LGrn = 3'b001;
    localparam logic [2:0] LOff = 3'b000;

    state_e           state_q, state_d, nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             demand_q, demand_d;
    logic             blink_q, blink_d;
    logic             tick, leave;

    assign tick  = (pre_q == PreMax);
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StAllRed;
            cnt_q    <= '0;
            pre_q    <= '0;
            demand_q <= 1'b0;
            blink_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            demand_q <= demand_d;
            blink_q  <= blink_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        demand_d = demand_q;
        blink_d  = blink_q;
        leave    = 1'b0;
        nxt      = state_q;

        case (state_q)
            StMGreen: begin
                leave = (cnt_q >= MainMin && demand_q) || (cnt_q == MainMax);
                nxt   = StM2Yel;
            end
            StM2Yel: begin
                leave = (cnt_q == YelEnd);
                nxt   = StMtGreen;
            end
            StMtGreen: begin
                leave = (cnt_q == TurnEnd);
                nxt   = StM1MtYel;
            end
            StM1MtYel: begin
                leave = (cnt_q == YelEnd);
                nxt   = demand_q ? StSGreen : StAllRed;
            end
            StSGreen: begin
                leave = (cnt_q == SideEnd);
                nxt   = StSYel;
            end
            StSYel: begin
                leave = (cnt_q == YelEnd);
                nxt   = StAllRed;
            end
            StAllRed: begin
                leave = (cnt_q == ClrEnd);
                nxt   = bus.flash_mode ? StFlash : StMGreen;
            end
            StFlash: begin
                leave = !bus.flash_mode;
                nxt   = StAllRed;
            end
            default: begin
                leave = 1'b1;
                nxt   = StAllRed;
            end
        endcase

        // Counter in FLASH may wrap; its value is never consulted there.
        if (tick) begin
            if (leave) begin
                state_d = nxt;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (tick && state_q == StFlash) blink_d = ~blink_q;
        if (state_d == StFlash && state_q != StFlash) blink_d = 1'b1;

        // Clear on side-green entry overrides a same-cycle request.
        if (bus.side_req && state_q != StSGreen) demand_d = 1'b1;
        if (state_d == StSGreen && state_q != StSGreen) demand_d = 1'b0;
    end

    logic [2:0] l_m1, l_m2, l_mt, l_s;

    always_comb begin
        l_m1 = LRed;
        l_m2 = LRed;
        l_mt = LRed;
        l_s  = LRed;
        case (state_q)
            StMGreen: begin
                l_m1 = LGrn;
                l_m2 = LGrn;
            end
            StM2Yel: begin
                l_m1 = LGrn;
                l_m2 = LYel;
            end
            StMtGreen: begin
                l_m1 = LGrn;
                l_mt = LGrn;
            end
            StM1MtYel: begin
                l_m1 = LYel;
                l_mt = LYel;
            end
            StSGreen: l_s = LGrn;
            StSYel:   l_s = LYel;
            StFlash: begin
                l_m1 = blink_q ? LYel : LOff;
                l_m2 = blink_q ? LYel : LOff;
                l_mt = blink_q ? LYel : LOff;
                l_s  = blink_q ? LRed : LOff;
            end
            default: ;
        endcase
    end

    assign bus.light_M1       = l_m1;
    assign bus.light_M2       = l_m2;
    assign bus.light_MT       = l_mt;
    assign bus.light_S        = l_s;
    assign bus.phase          = state_q;
    assign bus.demand_pending = demand_q;

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Parametrised junction controller for two main approaches (M1, M2), a main-road turn lane (MT) and a side road (S). Main green rests until side-road demand is latched; side phases are skipped when there is no demand. A flashing night mode is added, with an on-chip tick prescaler. Phase durations and tick rate are set by parameters.

Parameters:
TICK_DIV, 1, clk cycles per timing tick (>=1); prescaler counts 0..TICK_DIV-1 and pulses on TICK_DIV-1
T_MAIN, 7, minimum main green, ticks
T_MAIN_MAX, 20, maximum main green with no side demand, ticks (>=T_MAIN)
T_YEL, 2, every yellow interval, ticks
T_TURN, 5, turn-lane green, ticks
T_SIDE, 3, side-road green, ticks
T_CLR, 2, all-red clearance, ticks
CNT_W, 8, phase counter width; must hold T_MAIN_MAX-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
side_req  in  1  side-road vehicle/pedestrian request, level or pulse
flash_mode  in  1  night flashing mode request
light_M1  out  3  {red,yellow,green}: 100=R, 010=Y, 001=G, 000=off
light_M2  out  3  same encoding
light_MT  out  3  same encoding
light_S  out  3  same encoding
phase  out  3  current state encoding
demand_pending  out  1  latched side demand

Behaviour:
- States/encoding: M_GREEN=0, M2_YEL=1, MT_GREEN=2, M1MT_YEL=3, S_GREEN=4, S_YEL=5, ALL_RED=6, FLASH=7.
- Reset (rst=0, takes effect immediately with no clock edge): state ALL_RED, phase counter 0, prescaler 0, demand 0, blink=1. All lights 100 and demand_pending 0 while reset is held.
- Tick: one-cycle pulse when the prescaler wraps. With TICK_DIV=1 a tick occurs every cycle after reset release.
- Phase counter: cleared on every state entry; incremented on each tick. A phase of duration T exits on the tick where count==T-1, so each phase lasts exactly T ticks.
- Transitions:
  - M_GREEN -> M2_YEL on the tick where (count>=T_MAIN-1 and demand=1) or count==T_MAIN_MAX-1.
  - M2_YEL (T_YEL) -> MT_GREEN.
  - MT_GREEN (T_TURN) -> M1MT_YEL.
  - M1MT_YEL (T_YEL) -> S_GREEN if demand=1, else ALL_RED.
  - S_GREEN (T_SIDE) -> S_YEL (T_YEL) -> ALL_RED.
  - ALL_RED (T_CLR) -> FLASH if flash_mode=1 at the exit tick, else M_GREEN.
  - FLASH -> ALL_RED on the first tick with flash_mode=0.
  - Unused encodings -> ALL_RED.
- Lights, decoded from the state register (M1, M2, MT, S):
  - M_GREEN: G G R R
  - M2_YEL: G Y R R
  - MT_GREEN: G R G R
  - M1MT_YEL: Y R Y R
  - S_GREEN: R R R G
  - S_YEL: R R R Y
  - ALL_RED: R R R R
  - FLASH: blink=1 gives M1/M2/MT=010 and S=100; blink=0 gives all 000.
- Blink: set to 1 on FLASH entry; toggles on every tick while in FLASH.
- Demand latch:
  - Set on any clk where side_req=1, except while in S_GREEN.
  - Cleared on the transition into S_GREEN; clear wins if it coincides with a set.
  - side_req during S_GREEN is ignored. side_req in S_YEL re-latches demand.
- flash_mode is honoured only at the ALL_RED exit. It never truncates a green or yellow.
- No combinational path from inputs to lights.

Test Plan:
- No side_req, TICK_DIV=1, release reset -> ALL_RED 2 cycles, M_GREEN 20, M2_YEL 2, MT_GREEN 5, M1MT_YEL 2, ALL_RED 2, repeating; phase never 4 or 5; demand_pending stays 0.
- One-cycle side_req pulse in cycle 3 of M_GREEN -> demand_pending=1 from the next cycle; M_GREEN lasts exactly 7 cycles. Sequence: M2_YEL 2, MT_GREEN 5, M1MT_YEL 2, S_GREEN 3 (light_S=001, others 100), S_YEL 2, ALL_RED 2. demand_pending drops on S_GREEN entry.
- side_req held high continuously -> demand stays 0 throughout S_GREEN, re-latches in S_YEL; the next M_GREEN lasts 7 cycles; the side phase is served every cycle of the sequence.
- flash_mode asserted mid MT_GREEN -> normal sequence through ALL_RED, then FLASH. M1/M2/MT alternate 010/000 and S alternates 100/000 each cycle, starting lit. Deassert flash_mode -> ALL_RED 2 cycles, then M_GREEN.
- Drive rst=0 mid S_GREEN between clock edges -> immediately all lights 100, phase=6, demand_pending=0. After release, ALL_RED lasts 2 cycles.
- TICK_DIV=4, no demand -> every phase duration is 4x (ALL_RED 8 cycles, M_GREEN 80); counter changes only on tick cycles.
